// File: rtl/weave_row_if.sv
// ---------------------------------------------------------------------------
// weave_row_if
// Bundles the pattern-request and row-output handshake of weave_row_gen.
//
// Signals:
//   warp_in   WIDTH          warp word to expand, sampled on an accepted start
//   mode      2              pattern select, sampled on an accepted start
//   start     1              request a new pattern
//   row_out   WIDTH          current pattern row
//   row_valid 1              row_out/row_idx valid
//   row_ready 1              consumer takes the row when valid & ready
//   row_idx   $clog2(ROWS)   index of the current row
//   busy      1              pattern in progress
//   done      1              one-cycle pulse after the final row is taken
//
// Modports:
//   master  pattern requester / row consumer side
//   slave   the row generator itself
// ---------------------------------------------------------------------------
interface weave_row_if #(
   parameter int WIDTH = 8,
   parameter int ROWS  = 8
);
   localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic [WIDTH-1:0] warp_in;
   logic [1:0]       mode;
   logic             start;
   logic [WIDTH-1:0] row_out;
   logic             row_valid;
   logic             row_ready;
   logic [IDX_W-1:0] row_idx;
   logic             busy;
   logic             done;

   modport master (
      output warp_in, mode, start, row_ready,
      input  row_out, row_valid, row_idx, busy, done
   );

   modport slave (
      input  warp_in, mode, start, row_ready,
      output row_out, row_valid, row_idx, busy, done
   );
endinterface

// File: rtl/weave_row_gen.sv
// ---------------------------------------------------------------------------
// weave_row_gen
// Expands one warp word into a ROWS-row weave pattern (plain, twill-left,
// twill-right or hold) and hands the rows out one per valid/ready handshake.
//
// Parameters:
//   WIDTH  bits per row
//   ROWS   rows per pattern (>= 2)
//   STEP   rotate distance per row in the twill modes
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   weave_row_if.slave: start/warp_in/mode request, row_out/row_idx/
//         row_valid/row_ready handshake, busy and done status
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module weave_row_gen #(
   parameter int WIDTH = 8,
   parameter int ROWS  = 8,
   parameter int STEP  = 1
) (
   input  logic        clk,
   input  logic        rst,
   weave_row_if.slave  bus
);

   localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int SHIFT = STEP % WIDTH;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_e;

   typedef enum logic [1:0] {
      MODE_PLAIN   = 2'b00,
      MODE_TWILL_L = 2'b01,
      MODE_TWILL_R = 2'b10,
      MODE_HOLD    = 2'b11
   } mode_e;

   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Rotations are done on a doubled copy of the word so that a zero shift
   // falls out naturally without a special case.
   function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] x);
      logic [2*WIDTH-1:0] dbl;
      dbl = {x, x} << SHIFT;
      return dbl[2*WIDTH-1:WIDTH];
   endfunction

   function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] x);
      logic [2*WIDTH-1:0] dbl;
      dbl = {x, x} >> SHIFT;
      return dbl[WIDTH-1:0];
   endfunction

   // The pattern register always holds the row being presented, so each
   // accept only has to derive the following row from the current one:
   // plain flips every row, twill rotates one more STEP, hold keeps it.
   function automatic logic [WIDTH-1:0] next_row(input logic [WIDTH-1:0] cur,
                                                 input mode_e m);
      logic [WIDTH-1:0] nxt;
      nxt = cur;
      case (m)
         MODE_PLAIN:   nxt = ~cur;
         MODE_TWILL_L: nxt = rot_left(cur);
         MODE_TWILL_R: nxt = rot_right(cur);
         MODE_HOLD:    nxt = cur;
         default:      nxt = cur;
      endcase
      return nxt;
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers; a reset drops any partial pattern and
   // suppresses the done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= MODE_PLAIN;
         pat_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         pat_q   <= pat_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state and next-output logic. A start is only looked at in IDLE,
   // which includes the done cycle, so a start during the final accept is
   // dropped while one in the done cycle launches the next pattern.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      pat_d   = pat_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               mode_d  = mode_e'(bus.mode);
               pat_d   = bus.warp_in;
               idx_d   = '0;
               valid_d = 1'b1;
               busy_d  = 1'b1;
            end
         end

         RUN: begin
            if (bus.row_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
                  pat_d = next_row(pat_q, mode_q);
               end
            end
         end

         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign bus.row_out   = pat_q;
   assign bus.row_idx   = idx_q;
   assign bus.row_valid = valid_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_weave_row_gen.sv
// ---------------------------------------------------------------------------
// tb_weave_row_gen
// Drives two weave_row_gen instances (STEP=1 and STEP=3) with identical
// inputs. Each accepted start pushes the full expected row list, computed
// bit-by-bit from the weave rules, into a per-instance queue; a negedge
// monitor pops rows as they are handed over and checks row data, index,
// valid, busy, done and the reset state.
// ---------------------------------------------------------------------------
module tb_weave_row_gen;

   localparam int WIDTH = 8;
   localparam int ROWS  = 8;

   typedef struct {
      logic [7:0] value;
      int         idx;
      bit         last;
   } row_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_q = 1'b1;

   logic [7:0] warp_in   = 8'h00;
   logic [1:0] mode      = 2'b00;
   logic       start     = 1'b0;
   logic       row_ready = 1'b0;

   int compared   = 0;
   int mismatched = 0;

   row_exp_t exp_q[2][$];
   bit       exp_done[2] = '{1'b0, 1'b0};

   logic [7:0] out_v[2];
   logic [2:0] idx_v[2];
   logic       valid_v[2];
   logic       busy_v[2];
   logic       done_v[2];

   weave_row_if #(.WIDTH(WIDTH), .ROWS(ROWS)) bus1 ();
   weave_row_if #(.WIDTH(WIDTH), .ROWS(ROWS)) bus3 ();

   assign bus1.warp_in   = warp_in;
   assign bus1.mode      = mode;
   assign bus1.start     = start;
   assign bus1.row_ready = row_ready;
   assign bus3.warp_in   = warp_in;
   assign bus3.mode      = mode;
   assign bus3.start     = start;
   assign bus3.row_ready = row_ready;

   assign out_v[0]   = bus1.row_out;
   assign idx_v[0]   = bus1.row_idx;
   assign valid_v[0] = bus1.row_valid;
   assign busy_v[0]  = bus1.busy;
   assign done_v[0]  = bus1.done;
   assign out_v[1]   = bus3.row_out;
   assign idx_v[1]   = bus3.row_idx;
   assign valid_v[1] = bus3.row_valid;
   assign busy_v[1]  = bus3.busy;
   assign done_v[1]  = bus3.done;

   weave_row_gen #(.WIDTH(WIDTH), .ROWS(ROWS), .STEP(1)) dut_step1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   weave_row_gen #(.WIDTH(WIDTH), .ROWS(ROWS), .STEP(3)) dut_step3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   // 10 ns clock; all stimulus changes 1 ns after a rising edge.
   always #5 clk = ~clk;

   always @(posedge clk) rst_q <= rst;

   function automatic int step_for(input int inst);
      return (inst == 0) ? 1 : 3;
   endfunction

   // Reference row k of a pattern, straight from the weave rules.
   function automatic logic [7:0] model_row(input logic [7:0] w, input logic [1:0] m,
                                            input int k, input int step);
      logic [7:0] r;
      int sh;
      sh = (k * step) % WIDTH;
      r  = w;
      case (m)
         2'd0: r = (k % 2 == 1) ? ~w : w;
         2'd1: for (int b = 0; b < WIDTH; b++) r[(b + sh) % WIDTH] = w[b];
         2'd2: for (int b = 0; b < WIDTH; b++) r[b] = w[(b + sh) % WIDTH];
         default: r = w;
      endcase
      return r;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: compares every cycle, then consumes a row when the handshake
   // is expected to complete on the coming edge.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst_q) begin
            check_output($sformatf("dut%0d reset row_out", i), 32'(out_v[i]), 32'h0);
            check_output($sformatf("dut%0d reset row_idx", i), 32'(idx_v[i]), 32'h0);
            check_output($sformatf("dut%0d reset row_valid", i), 32'(valid_v[i]), 32'h0);
            check_output($sformatf("dut%0d reset busy", i), 32'(busy_v[i]), 32'h0);
            check_output($sformatf("dut%0d reset done", i), 32'(done_v[i]), 32'h0);
         end else begin
            check_output($sformatf("dut%0d done", i), 32'(done_v[i]), 32'(exp_done[i]));
            check_output($sformatf("dut%0d busy", i), 32'(busy_v[i]), 32'(exp_q[i].size() != 0));
            check_output($sformatf("dut%0d row_valid", i), 32'(valid_v[i]), 32'(exp_q[i].size() != 0));
            if (exp_q[i].size() != 0) begin
               check_output($sformatf("dut%0d row_out", i), 32'(out_v[i]), 32'(exp_q[i][0].value));
               check_output($sformatf("dut%0d row_idx", i), 32'(idx_v[i]), 32'(exp_q[i][0].idx));
            end
         end
         exp_done[i] = 1'b0;
         if (rst) begin
            exp_q[i].delete();
         end else if (row_ready && exp_q[i].size() != 0) begin
            row_exp_t e;
            e = exp_q[i].pop_front();
            exp_done[i] = e.last;
         end
      end
   end

   // Entered at a rising edge; leaves at a rising edge after n reset edges.
   task automatic reset_dut(input int n);
      #1;
      rst   = 1'b1;
      start = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
   endtask

   task automatic idle_cycles(input int n);
      #1;
      start     = 1'b0;
      row_ready = 1'($urandom_range(0, 1));
      repeat (n) @(posedge clk);
   endtask

   // Launches one pattern and runs it to its final accept (returning on that
   // edge, so a following call starts in the done cycle).
   //   style 0: ready always high; 1: random ready; 2: stall row 2 for 3 cycles
   //   spurious: pulse start while running and on the final-accept cycle
   //   abort_at: row on which to assert reset instead of finishing (-1: none)
   task automatic apply_stimulus(input logic [7:0] w, input logic [1:0] m,
                                 input int style, input bit spurious, input int abort_at);
      int  stall;
      int  row;
      bit  last;
      row_exp_t e;
      stall = 0;
      #1;
      start     = 1'b1;
      warp_in   = w;
      mode      = m;
      row_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < ROWS; k++) begin
            e.value = model_row(w, m, k, step_for(i));
            e.idx   = k;
            e.last  = (k == ROWS - 1);
            exp_q[i].push_back(e);
         end
      end
      #1;
      for (int c = 0; c < 300; c++) begin
         row = ROWS - exp_q[0].size();
         if (abort_at >= 0 && row == abort_at) begin
            rst   = 1'b1;
            start = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(posedge clk);
            return;
         end
         case (style)
            0: row_ready = 1'b1;
            2: begin
               if (row == 2 && stall < 3) begin
                  row_ready = 1'b0;
                  stall++;
               end else begin
                  row_ready = 1'b1;
               end
            end
            default: row_ready = 1'($urandom_range(0, 1));
         endcase
         last    = (exp_q[0].size() == 1) && row_ready;
         start   = spurious && (last || $urandom_range(0, 3) == 0);
         warp_in = 8'($urandom);
         mode    = 2'($urandom);
         @(posedge clk);
         if (last) return;
         #1;
      end
      check_output("pattern completion", 32'(exp_q[0].size()), 32'h0);
   endtask

   initial begin
      reset_dut(2);
      idle_cycles(3);

      apply_stimulus(8'h0F, 2'b01, 0, 1'b0, -1);
      idle_cycles(2);
      apply_stimulus(8'hA5, 2'b00, 2, 1'b0, -1);
      idle_cycles(1);
      apply_stimulus(8'h01, 2'b10, 0, 1'b0, -1);
      apply_stimulus(8'h3C, 2'b11, 1, 1'b1, -1);
      apply_stimulus(8'h5B, 2'b01, 1, 1'b0, 3);
      idle_cycles(2);

      for (int n = 0; n < 14; n++) begin
         apply_stimulus(8'($urandom), 2'($urandom), int'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), -1);
         if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
      end

      idle_cycles(4);
      check_output("dut0 queue drained", 32'(exp_q[0].size()), 32'h0);
      check_output("dut1 queue drained", 32'(exp_q[1].size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
